adc_capture_sched: RTL and testbench



---
 rtl/adc_capture_sched.sv | 219 +++++++++++++++++++++
 tb/tb_adc_capture_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sched.sv
// adc_capture_sched: N-channel ADC conversion scheduler.
// One start strobe enables every ADC front-end; each channel is captured
// independently, negative codes are clamped to zero, and a single
// end-of-conversion strobe closes the round. A round that does not finish
// within TIMEOUT_CYCLES is aborted and the missing channels are flagged.
// Also counts ignored start requests and measures completed rounds per
// RATE_WINDOW cycles.
// Optional build macro: ADC_CAPTURE_IIR_EN adds a first-order IIR filter
// per channel on sample_o (y <= y + ((x - y) >>> 2)).
module adc_capture_sched #(
    parameter int N_CH           = 2,
    parameter int DATA_W         = 16,
    parameter int OUT_W          = 12,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RATE_WINDOW    = 27000000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [N_CH-1:0]        adc_ready_i,
    input  logic [N_CH*DATA_W-1:0] adc_data_i,
    output logic [N_CH-1:0]        adc_enable_o,
    output logic [N_CH*OUT_W-1:0]  sample_o,
    output logic                   eoc_o,
    output logic                   timeout_o,
    output logic [N_CH-1:0]        err_o,
    output logic                   busy_o,
    output logic [7:0]             overrun_o,
    output logic [15:0]            rate_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WIN_W = $clog2(RATE_WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    state_t                  state;
    logic [TMR_W-1:0]        timer;
    logic [N_CH-1:0]         done;
    logic [N_CH-1:0]         cap;
    logic [N_CH*OUT_W-1:0]   clamped;
    logic                    tmo_hit;
    logic [WIN_W-1:0]        win_cnt;
    logic [15:0]             round_cnt;
    logic [15:0]             round_next;
    logic                    unused_raw_lsbs;

    // Per-channel clamp of the raw word and capture qualification
    always_comb begin
        clamped = '0;
        cap     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (adc_data_i[k*DATA_W + DATA_W - 1])
                clamped[k*OUT_W +: OUT_W] = '0;
            else
                clamped[k*OUT_W +: OUT_W] = adc_data_i[k*DATA_W + DATA_W - 2 -: OUT_W];
            cap[k] = (state == CAPTURE) && adc_ready_i[k] && !done[k];
        end
    end

    // Raw bits below the output slice are dropped by truncation
    always_comb unused_raw_lsbs = ^adc_data_i;

    // Timeout fires on the last permitted ARM/CAPTURE cycle
    always_comb tmo_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Round sequencing: arm, capture, end-of-conversion or abort
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            timer        <= '0;
            done         <= '0;
            adc_enable_o <= '0;
            err_o        <= '0;
            eoc_o        <= 1'b0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            eoc_o     <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= ARM;
                        adc_enable_o <= '1;
                        busy_o       <= 1'b1;
                        timer        <= '0;
                        done         <= '0;
                        err_o        <= '0;
                    end
                end
                ARM: begin
                    timer <= timer + 1'b1;
                    if (tmo_hit) begin
                        state        <= IDLE;
                        adc_enable_o <= '0;
                        err_o        <= ~done;
                        eoc_o        <= 1'b1;
                        timeout_o    <= 1'b1;
                        busy_o       <= 1'b0;
                    end else if (adc_ready_i == '0) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    timer        <= timer + 1'b1;
                    done         <= done | cap;
                    adc_enable_o <= adc_enable_o & ~cap;
                    // A round already complete in this cycle ends normally
                    // even when the timer reaches its limit at the same time.
                    if (&done) begin
                        state <= DONE;
                        eoc_o <= 1'b1;
                    end else if (tmo_hit) begin
                        state        <= IDLE;
                        adc_enable_o <= '0;
                        err_o        <= ~(done | cap);
                        eoc_o        <= 1'b1;
                        timeout_o    <= 1'b1;
                        busy_o       <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_CAPTURE_IIR_EN
    logic [N_CH-1:0] primed;

    function automatic logic [OUT_W-1:0] iir_step(input logic [OUT_W-1:0] y,
                                                  input logic [OUT_W-1:0] x);
        logic signed [OUT_W+1:0] ys;
        logic signed [OUT_W+1:0] xs;
        logic signed [OUT_W+1:0] acc;
        ys  = $signed({2'b00, y});
        xs  = $signed({2'b00, x});
        acc = ys + ((xs - ys) >>> 2);
        if (acc < 0)
            return '0;
        else if (acc > $signed({2'b00, {OUT_W{1'b1}}}))
            return '1;
        else
            return acc[OUT_W-1:0];
    endfunction

    // Filtered sample update; first capture after reset seeds the filter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_o <= '0;
            primed   <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (cap[k]) begin
                    primed[k] <= 1'b1;
                    if (primed[k])
                        sample_o[k*OUT_W +: OUT_W] <= iir_step(sample_o[k*OUT_W +: OUT_W],
                                                               clamped[k*OUT_W +: OUT_W]);
                    else
                        sample_o[k*OUT_W +: OUT_W] <= clamped[k*OUT_W +: OUT_W];
                end
            end
        end
    end
`else
    // Raw clamped sample capture; missed channels keep their last value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_o <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (cap[k])
                    sample_o[k*OUT_W +: OUT_W] <= clamped[k*OUT_W +: OUT_W];
            end
        end
    end
`endif

    // Saturating count of start requests arriving outside IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            overrun_o <= '0;
        else if (start_i && (state != IDLE) && (overrun_o != 8'hFF))
            overrun_o <= overrun_o + 8'd1;
    end

    // Completed (non-aborted) rounds including the current cycle's strobe
    always_comb begin
        round_next = round_cnt;
        if (eoc_o && !timeout_o && (round_cnt != 16'hFFFF))
            round_next = round_cnt + 16'd1;
    end

    // Free-running rate window; publishes the round count at window end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt   <= '0;
            round_cnt <= '0;
            rate_o    <= '0;
        end else if (win_cnt == WIN_W'(RATE_WINDOW - 1)) begin
            win_cnt   <= '0;
            round_cnt <= '0;
            rate_o    <= round_next;
        end else begin
            win_cnt   <= win_cnt + 1'b1;
            round_cnt <= round_next;
        end
    end

endmodule

// File: tb/tb_adc_capture_sched.sv
// Testbench for adc_capture_sched: table-driven rounds, hand-written
// corner sequences and randomized rounds against a cycle-level model.
module tb_adc_capture_sched;

    localparam int N_CH = 2;
    localparam int DW   = 16;
    localparam int OW   = 12;
    localparam int TO   = 100;
    localparam int RW   = 1000;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 start_i = 1'b0;
    logic [N_CH-1:0]      adc_ready_i = '0;
    logic [N_CH*DW-1:0]   adc_data_i = '0;
    logic [N_CH-1:0]      adc_enable_o;
    logic [N_CH*OW-1:0]   sample_o;
    logic                 eoc_o;
    logic                 timeout_o;
    logic [N_CH-1:0]      err_o;
    logic                 busy_o;
    logic [7:0]           overrun_o;
    logic [15:0]          rate_o;

    adc_capture_sched #(
        .N_CH(N_CH), .DATA_W(DW), .OUT_W(OW),
        .TIMEOUT_CYCLES(TO), .RATE_WINDOW(RW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .adc_ready_i(adc_ready_i), .adc_data_i(adc_data_i),
        .adc_enable_o(adc_enable_o), .sample_o(sample_o),
        .eoc_o(eoc_o), .timeout_o(timeout_o), .err_o(err_o),
        .busy_o(busy_o), .overrun_o(overrun_o), .rate_o(rate_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // model state
    int          gcyc;
    int          win_rounds[0:127];
    logic [11:0] exp_smp[2];
    bit          primed[2];
    int          exp_ovr;

    always @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) gcyc <= 0;
        else         gcyc <= gcyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1);
    end

    typedef struct {
        int          d0, d1;
        logic [15:0] w0, w1;
        logic [11:0] c0, c1;
        int          eoc;
        bit          to;
        logic [1:0]  err;
        int          extra;
        bit          sdone;
    } vec_t;

    vec_t vt[10];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] clamp(input logic [15:0] w);
        if (w[DW-1]) return '0;
        return w[DW-2 -: OW];
    endfunction

    function automatic logic [11:0] apply(input int k, input logic [11:0] x);
        int r;
        r = int'(x);
`ifdef ADC_CAPTURE_IIR_EN
        if (primed[k]) begin
            r = int'(exp_smp[k]) + ((int'(x) - int'(exp_smp[k])) >>> 2);
            if (r < 0) r = 0;
            if (r > 4095) r = 4095;
        end
`endif
        primed[k] = 1'b1;
        return 12'(r);
    endfunction

    function automatic void predict(input int d0, input int d1, output int eoc,
                                    output bit to, output logic [1:0] err);
        int last;
        last = (d0 > d1) ? d0 : d1;
        if (d0 >= 0 && d1 >= 0 && last <= TO - 1) begin
            eoc = last + 2;
            to  = 1'b0;
            err = 2'b00;
        end else begin
            eoc    = TO + 1;
            to     = 1'b1;
            err[0] = !(d0 >= 0 && d0 <= TO);
            err[1] = !(d1 >= 0 && d1 <= TO);
        end
    endfunction

    task automatic check_rate(input string name);
        int w;
        int e;
        w = gcyc / RW;
        e = (w == 0) ? 0 : win_rounds[w-1];
        if (e > 16'hFFFF) e = 16'hFFFF;
        chk(name, rate_o, e);
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, " enable"}, adc_enable_o, 0);
        chk({p, " sample"}, sample_o, 0);
        chk({p, " eoc"}, eoc_o, 0);
        chk({p, " timeout"}, timeout_o, 0);
        chk({p, " err"}, err_o, 0);
        chk({p, " busy"}, busy_o, 0);
        chk({p, " overrun"}, overrun_o, 0);
        chk({p, " rate"}, rate_o, 0);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        adc_ready_i = '0;
        adc_data_i  = '0;
        repeat (3) tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 128; i++) win_rounds[i] = 0;
        exp_smp[0] = '0; exp_smp[1] = '0;
        primed[0]  = 1'b0; primed[1] = 1'b0;
        exp_ovr    = 0;
    endtask

    // One complete round; cycle 0 carries the start pulse.
    task automatic run_round(input string name, input int d0, input int d1,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [11:0] c0, input logic [11:0] c1,
                             input int exp_eoc, input bit exp_to, input logic [1:0] exp_err,
                             input int n_extra, input bit start_done);
        int          d[2];
        logic [15:0] w[2];
        logic [11:0] cv[2];
        int          eoc_cnt;
        int          eoc_at;
        logic        to_seen;
        bit          en_bad;
        bit          busy_bad;
        bit          exp_en;
        int          g0;
        d[0] = d0; d[1] = d1; w[0] = w0; w[1] = w1; cv[0] = c0; cv[1] = c1;
        eoc_cnt = 0; eoc_at = -1; to_seen = 1'b0; en_bad = 1'b0; busy_bad = 1'b0;
        g0 = gcyc;
        for (int c = 0; c <= exp_eoc + 1; c++) begin
            if (eoc_o === 1'b1) begin
                eoc_cnt++;
                if (eoc_at < 0) begin
                    eoc_at  = c;
                    to_seen = timeout_o;
                end
            end
            if (c >= 1 && c < exp_eoc) begin
                for (int k = 0; k < 2; k++) begin
                    exp_en = !(!exp_err[k] && d[k] >= 0 && c > d[k]);
                    if (adc_enable_o[k] !== exp_en) en_bad = 1'b1;
                end
                if (busy_o !== 1'b1) busy_bad = 1'b1;
            end
            start_i = (c == 0) || ((c % 2 == 1) && (c < 2 * n_extra)) ||
                      (start_done && c == exp_eoc);
            if (c >= 1) begin
                for (int k = 0; k < 2; k++) begin
                    adc_ready_i[k] = (d[k] >= 0) && (c >= d[k]);
                    adc_data_i[k*DW +: DW] = (d[k] < 0 || c <= d[k]) ? w[k] : 16'($urandom);
                end
            end
            tick();
        end
        start_i = 1'b0;
        exp_ovr = exp_ovr + n_extra + (start_done ? 1 : 0);
        if (exp_ovr > 255) exp_ovr = 255;
        for (int k = 0; k < 2; k++)
            if (!exp_err[k]) exp_smp[k] = apply(k, cv[k]);
        if (!exp_to) win_rounds[(g0 + exp_eoc) / RW]++;
        chk({name, " eoc count"}, eoc_cnt, 1);
        chk({name, " eoc cycle"}, eoc_at, exp_eoc);
        chk({name, " timeout"}, to_seen, exp_to);
        chk({name, " enable in round"}, en_bad, 0);
        chk({name, " busy in round"}, busy_bad, 0);
        chk({name, " err"}, err_o, exp_err);
        chk({name, " enable after"}, adc_enable_o, 0);
        chk({name, " busy after"}, busy_o, 0);
        chk({name, " sample0"}, sample_o[0 +: OW], exp_smp[0]);
        chk({name, " sample1"}, sample_o[OW +: OW], exp_smp[1]);
        chk({name, " overrun"}, overrun_o, exp_ovr);
        check_rate({name, " rate"});
    endtask

    initial begin
        int          ev;
        bit          et;
        logic [1:0]  ee;
        int          rd[2];
        logic [15:0] rw[2];
        int          sel;
        int          nx;
        bit          sd;
        bit          eoc_bad;

        //         d0   d1   w0        w1        c0      c1      eoc  to  err    extra sdone
        vt[0] = '{ 10,  25,  16'h3A98, 16'h1F40, 12'h753, 12'h3E8, 27, 0, 2'b00, 0, 0};
        vt[1] = '{  6,   8,  16'hFF10, 16'h7FFF, 12'h000, 12'hFFF, 10, 0, 2'b00, 0, 0};
        vt[2] = '{ 12,  -1,  16'h1234, 16'h5555, 12'h246, 12'h000, 101, 1, 2'b10, 0, 0};
        vt[3] = '{ 20,  15,  16'h0008, 16'h4000, 12'h001, 12'h800, 22, 0, 2'b00, 3, 0};
        vt[4] = '{  5,   5,  16'h7FF8, 16'h8000, 12'hFFF, 12'h000,  7, 0, 2'b00, 0, 1};
        vt[5] = '{  2,   2,  16'h0010, 16'h0018, 12'h002, 12'h003,  4, 0, 2'b00, 0, 0};
        vt[6] = '{100,  30,  16'h2000, 16'h1000, 12'h400, 12'h200, 101, 1, 2'b00, 0, 0};
        vt[7] = '{ -1,  -1,  16'h1111, 16'h2222, 12'h000, 12'h000, 101, 1, 2'b11, 0, 0};
        vt[8] = '{ -1, 100,  16'h3333, 16'h0C80, 12'h000, 12'h190, 101, 1, 2'b01, 0, 0};
        vt[9] = '{  1,   1,  16'h4444, 16'h4444, 12'h000, 12'h000, 101, 1, 2'b11, 0, 0};

        // reset state
        rst_ni = 1'b0;
        repeat (2) tick();
        chk_all_zero("in reset");
        do_reset();
        chk_all_zero("after reset");

        // table-driven rounds
        for (int i = 0; i < 10; i++)
            run_round($sformatf("vec%0d", i), vt[i].d0, vt[i].d1, vt[i].w0, vt[i].w1,
                      vt[i].c0, vt[i].c1, vt[i].eoc, vt[i].to, vt[i].err,
                      vt[i].extra, vt[i].sdone);

        // randomized rounds against the model
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 2; k++) begin
                sel   = int'($urandom_range(0, 9));
                rd[k] = (sel == 0) ? -1 : (sel == 1) ? 100 : int'($urandom_range(2, 98));
                rw[k] = 16'($urandom);
            end
            predict(rd[0], rd[1], ev, et, ee);
            nx = int'($urandom_range(0, 3));
            if (nx > ev / 2) nx = ev / 2;
            sd = !et && ($urandom_range(0, 1) == 1);
            run_round($sformatf("rnd%0d", r), rd[0], rd[1], rw[0], rw[1],
                      clamp(rw[0]), clamp(rw[1]), ev, et, ee, nx, sd);
        end

        // rate meter: 7 rounds in the first window, last eoc on its final cycle
        do_reset();
        for (int r = 0; r < 6; r++)
            run_round($sformatf("rate%0d", r), 3, 4, 16'h0100, 16'h0200,
                      12'h020, 12'h040, 6, 0, 2'b00, 0, 0);
        while (gcyc < RW - 1 - 6) tick();
        chk("rate before boundary", rate_o, 0);
        run_round("rate6", 3, 4, 16'h0100, 16'h0200, 12'h020, 12'h040, 6, 0, 2'b00, 0, 0);
        chk("rate at boundary", rate_o, 7);
        while (gcyc < 2 * RW - 1) tick();
        chk("rate held in idle window", rate_o, 7);
        tick();
        chk("rate after empty window", rate_o, 0);

        // overrun saturation over long aborted rounds
        for (int r = 0; r < 6; r++)
            run_round($sformatf("sat%0d", r), -1, -1, 16'h0, 16'h0, 12'h0, 12'h0,
                      TO + 1, 1, 2'b11, 50, 0);
        chk("overrun saturated", overrun_o, 255);

        // reset in the middle of CAPTURE
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        adc_ready_i = '0;
        tick();
        adc_ready_i[0] = 1'b1;
        adc_data_i[0 +: DW] = 16'h3A98;
        tick();
        tick();
        chk("pre-reset busy", busy_o, 1);
        chk("pre-reset enable", adc_enable_o, 2'b10);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("async reset");
        repeat (2) tick();
        adc_ready_i = '0;
        rst_ni = 1'b1;
        for (int i = 0; i < 128; i++) win_rounds[i] = 0;
        exp_smp[0] = '0; exp_smp[1] = '0;
        primed[0] = 1'b0; primed[1] = 1'b0;
        exp_ovr = 0;
        eoc_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (eoc_o !== 1'b0 || busy_o !== 1'b0) eoc_bad = 1'b1;
            tick();
        end
        chk("no eoc after reset abort", eoc_bad, 0);

        // filter seeding and first update (raw path passes captures through)
        run_round("iir a", 3, 3, 16'h0C80, 16'h0C80, 12'd400, 12'd400, 5, 0, 2'b00, 0, 0);
        chk("iir first ch0", sample_o[0 +: OW], 400);
        run_round("iir b", 3, 3, 16'h1900, 16'h1900, 12'd800, 12'd800, 5, 0, 2'b00, 0, 0);
`ifdef ADC_CAPTURE_IIR_EN
        chk("iir second ch0", sample_o[0 +: OW], 500);
`else
        chk("raw second ch0", sample_o[0 +: OW], 800);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
